// File: rtl/game_ram_arbiter_if.sv
// Requester handshake and game-table RAM port bundle for game_ram_arbiter.
// The arbiter takes the slave modport; requesters and the RAM sit on the master side.
interface game_ram_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 10
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_rdata;
  logic                    err_addr;

  modport slave (
    input  req, we, lock, addr, wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata, err_addr
  );

  modport master (
    output req, we, lock, addr, wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata, err_addr
  );

endinterface

// File: rtl/game_ram_arbiter.sv
// Round-robin req/gnt arbiter sharing the single-port game table RAM, with locked bursts.
// Build macro GAME_RAM_PRIO_EN gives requester 0 strict priority when arbitrating.
module game_ram_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 10,
  parameter int ROWS      = 10,
  parameter int MAX_BURST = 10
) (
  input  logic              clk_40M,
  input  logic              rst,
  game_ram_arbiter_if.slave bus_if
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W:0]   ROWS_LIM   = (ADDR_W + 1)'(ROWS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [N_REQ-1:0]   gnt_q,       gnt_d;
  logic [IDX_W-1:0]   owner_q,     owner_d;
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0]   rvalid_q,    rvalid_d;
  logic               rd_oor_q,    rd_oor_d;
  logic [DATA_W-1:0]  rdata_q,     rdata_d;
  logic               err_q,       err_d;

  logic               sel_req_s;
  logic               sel_we_s;
  logic               sel_lock_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               in_range_s;
  logic               fire_s;
  logic               win_found_s;
  logic               win_upd_s;
  logic               hit_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [IDX_W-1:0]   cand_s;

  // Index reached by stepping 'step' places past 'base', wrapping at N_REQ.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] base, input int step);
    next_idx = IDX_W'((int'(base) + step) % N_REQ);
  endfunction

  // Select the current owner's request fields.
  always_comb begin
    sel_req_s   = bus_if.req[owner_q] & gnt_q[owner_q];
    sel_we_s    = bus_if.we[owner_q];
    sel_lock_s  = bus_if.lock[owner_q];
    sel_addr_s  = bus_if.addr[owner_q * ADDR_W +: ADDR_W];
    sel_wdata_s = bus_if.wdata[owner_q * DATA_W +: DATA_W];
    in_range_s  = ({1'b0, sel_addr_s} < ROWS_LIM);
    if (state_q == ST_OWN) begin
      fire_s = sel_req_s;
    end else begin
      fire_s = 1'b0;
    end
  end

  // Pick the next owner: search upward from the slot after the last round-robin winner.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_upd_s   = 1'b1;
    hit_s       = 1'b0;
    cand_s      = '0;
`ifdef GAME_RAM_PRIO_EN
    if (bus_if.req[0]) begin
      win_found_s = 1'b1;
      win_idx_s   = '0;
      win_upd_s   = 1'b0;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand_s      = next_idx(rr_ptr_q, k);
        hit_s       = !win_found_s && (cand_s != '0) && bus_if.req[cand_s];
        win_idx_s   = hit_s ? cand_s : win_idx_s;
        win_found_s = win_found_s | hit_s;
      end
    end
`else
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s      = next_idx(rr_ptr_q, k);
      hit_s       = !win_found_s && bus_if.req[cand_s];
      win_idx_s   = hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
`endif
  end

  // Grant FSM: one access per grant unless locked, always returning through IDLE.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d     = ST_OWN;
          gnt_d       = N_REQ'(1) << win_idx_s;
          owner_d     = win_idx_s;
          burst_cnt_d = '0;
          if (win_upd_s) begin
            rr_ptr_d = win_idx_s;
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (fire_s) begin
          // Out-of-range accesses still count towards the burst.
          if (sel_lock_s && (burst_cnt_q < BURST_LAST)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            state_d     = ST_OWN;
          end else begin
            burst_cnt_d = '0;
            gnt_d       = '0;
            state_d     = ST_IDLE;
          end
        end else begin
          burst_cnt_d = '0;
          gnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        owner_d     = '0;
        rr_ptr_d    = LAST_IDX;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Read-return tracking and the sticky range error.
  always_comb begin
    rvalid_d = '0;
    rd_oor_d = 1'b0;
    err_d    = err_q;
    if (fire_s) begin
      if (!sel_we_s) begin
        rvalid_d[owner_q] = 1'b1;
        rd_oor_d          = !in_range_s;
      end else begin
        rd_oor_d = 1'b0;
      end
      if (!in_range_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      rd_oor_d = 1'b0;
    end
  end

  // RAM strobes are live in the fire cycle so the RAM sees the access at the closing edge.
  always_comb begin
    if (fire_s && in_range_s) begin
      bus_if.ram_en    = 1'b1;
      bus_if.ram_we    = sel_we_s;
      bus_if.ram_addr  = sel_addr_s;
      bus_if.ram_wdata = sel_wdata_s;
    end else begin
      bus_if.ram_en    = 1'b0;
      bus_if.ram_we    = 1'b0;
      bus_if.ram_addr  = '0;
      bus_if.ram_wdata = '0;
    end
  end

  // RAM data passes straight through while rvalid is up, otherwise the last value is held.
  always_comb begin
    if (|rvalid_q) begin
      if (rd_oor_q) begin
        rdata_d = '0;
      end else begin
        rdata_d = bus_if.ram_rdata;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= LAST_IDX;
      burst_cnt_q <= '0;
      rvalid_q    <= '0;
      rd_oor_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
      rd_oor_q    <= rd_oor_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus_if.gnt      = gnt_q;
  assign bus_if.rvalid   = rvalid_q;
  assign bus_if.rdata    = rdata_d;
  assign bus_if.err_addr = err_q;

endmodule

// File: tb/tb_game_ram_arbiter.sv
// Directed bench for game_ram_arbiter with a 10x10 synchronous RAM model on the RAM port.
`timescale 1ns/1ps
module tb_game_ram_arbiter;

  logic clk_40M;
  logic rst;
  int   checks_cnt;
  int   errors_cnt;
  logic [9:0] mem [0:9];
  logic [31:0] exp_rr [0:7];
  logic [31:0] exp_alt [0:5];

  game_ram_arbiter_if bus_if ();

  game_ram_arbiter dut (
    .clk_40M (clk_40M),
    .rst     (rst),
    .bus_if  (bus_if)
  );

  initial begin
    clk_40M = 1'b0;
    forever #5 clk_40M = ~clk_40M;
  end

  // Synchronous-read RAM: data for an access fired in cycle t appears in cycle t+1.
  always @(posedge clk_40M) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) mem[i] <= 10'h000;
      mem[3] <= 10'h2A5;
      bus_if.ram_rdata <= 10'h000;
    end else if (bus_if.ram_en && (bus_if.ram_addr < 4'd10)) begin
      if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
      else bus_if.ram_rdata <= mem[bus_if.ram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_40M);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_40M);
  endtask

  initial begin
    checks_cnt   = 0;
    errors_cnt   = 0;
    exp_rr[0] = 32'h0; exp_rr[1] = 32'h1; exp_rr[2] = 32'h0; exp_rr[3] = 32'h2;
    exp_rr[4] = 32'h0; exp_rr[5] = 32'h4; exp_rr[6] = 32'h0; exp_rr[7] = 32'h1;
    exp_alt[0] = 32'h0; exp_alt[1] = 32'h2; exp_alt[2] = 32'h0;
    exp_alt[3] = 32'h4; exp_alt[4] = 32'h0; exp_alt[5] = 32'h2;
    rst          = 1'b1;
    bus_if.req   = 3'b000;
    bus_if.we    = 3'b000;
    bus_if.lock  = 3'b000;
    bus_if.addr  = 12'h000;
    bus_if.wdata = 30'h0;
    repeat (2) @(posedge clk_40M);
    mid();
    check_val("rst_gnt",    32'(bus_if.gnt),       32'h0);
    check_val("rst_rvalid", 32'(bus_if.rvalid),    32'h0);
    check_val("rst_rdata",  32'(bus_if.rdata),     32'h0);
    check_val("rst_ram_en", 32'(bus_if.ram_en),    32'h0);
    check_val("rst_ram_we", 32'(bus_if.ram_we),    32'h0);
    check_val("rst_raddr",  32'(bus_if.ram_addr),  32'h0);
    check_val("rst_rwdata", 32'(bus_if.ram_wdata), 32'h0);
    check_val("rst_err",    32'(bus_if.err_addr),  32'h0);

    // Single read by requester 1 of row 3.
    next_cycle();
    rst = 1'b0;
    bus_if.req = 3'b010;
    bus_if.addr[7:4] = 4'd3;
    mid();
    check_val("s1_idle_gnt", 32'(bus_if.gnt), 32'h0);
    next_cycle();
    mid();
    check_val("s1_gnt",    32'(bus_if.gnt),      32'h2);
    check_val("s1_ram_en", 32'(bus_if.ram_en),   32'h1);
    check_val("s1_raddr",  32'(bus_if.ram_addr), 32'h3);
    check_val("s1_ram_we", 32'(bus_if.ram_we),   32'h0);
    next_cycle();
    bus_if.req = 3'b000;
    mid();
    check_val("s1_gnt_drop", 32'(bus_if.gnt),    32'h0);
    check_val("s1_rvalid",   32'(bus_if.rvalid), 32'h2);
    check_val("s1_rdata",    32'(bus_if.rdata),  32'h2A5);
    next_cycle();
    mid();
    check_val("s1_rvalid_end", 32'(bus_if.rvalid), 32'h0);
    check_val("s1_rdata_hold", 32'(bus_if.rdata),  32'h2A5);

    // All three requesting from reset: 0,1,2,0 with an idle cycle between grants.
    next_cycle();
    rst = 1'b1;
    mid();
    check_val("s2_rst_rdata", 32'(bus_if.rdata), 32'h0);
    next_cycle();
    rst = 1'b0;
    bus_if.req  = 3'b111;
    bus_if.addr = 12'h333;
    for (int c = 0; c < 8; c++) begin
      mid();
      check_val("rr_gnt", 32'(bus_if.gnt), exp_rr[c]);
      if (c == 2) begin
        check_val("rr_rvalid", 32'(bus_if.rvalid), 32'h1);
        check_val("rr_rdata",  32'(bus_if.rdata),  32'h2A5);
      end
      next_cycle();
    end
    // Requester 0 idle: 1 and 2 alternate.
    bus_if.req = 3'b110;
    for (int c = 0; c < 6; c++) begin
      mid();
      check_val("alt_gnt", 32'(bus_if.gnt), exp_alt[c]);
      next_cycle();
    end
    bus_if.req = 3'b000;
    mid();
    check_val("alt_idle", 32'(bus_if.gnt), 32'h0);

    // Locked burst by requester 2 capped at 10 accesses; pending requester 0 follows.
    next_cycle();
    bus_if.req   = 3'b101;
    bus_if.we    = 3'b100;
    bus_if.lock  = 3'b100;
    bus_if.addr  = 12'h003;
    bus_if.wdata[29:20] = 10'h040;
    mid();
    check_val("b_idle_gnt", 32'(bus_if.gnt), 32'h0);
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      mid();
      check_val("b_gnt",    32'(bus_if.gnt),       32'h4);
      check_val("b_raddr",  32'(bus_if.ram_addr),  32'(k));
      check_val("b_rwdata", 32'(bus_if.ram_wdata), 32'h040 + 32'(k));
      next_cycle();
      bus_if.addr[11:8]   = 4'((k + 1) % 10);
      bus_if.wdata[29:20] = 10'h040 + 10'(k + 1);
    end
    mid();
    check_val("b_cap_gnt",    32'(bus_if.gnt),    32'h0);
    check_val("b_cap_ram_en", 32'(bus_if.ram_en), 32'h0);
    next_cycle();
    bus_if.req = 3'b001;
    mid();
    check_val("b_next_gnt",   32'(bus_if.gnt),      32'h1);
    check_val("b_next_raddr", 32'(bus_if.ram_addr), 32'h3);
    next_cycle();
    bus_if.req  = 3'b000;
    bus_if.we   = 3'b000;
    bus_if.lock = 3'b000;
    mid();
    check_val("b_next_rvalid", 32'(bus_if.rvalid), 32'h1);
    check_val("b_next_rdata",  32'(bus_if.rdata),  32'h043);
    check_val("b_mem0",        32'(mem[0]),        32'h040);
    check_val("b_mem9",        32'(mem[9]),        32'h049);

    // Out-of-range write then read by requester 0.
    next_cycle();
    bus_if.req  = 3'b001;
    bus_if.we   = 3'b001;
    bus_if.addr = 12'h00C;
    bus_if.wdata[9:0] = 10'h3FF;
    mid();
    check_val("oor_idle_gnt", 32'(bus_if.gnt), 32'h0);
    next_cycle();
    mid();
    check_val("oor_w_gnt",    32'(bus_if.gnt),      32'h1);
    check_val("oor_w_ram_en", 32'(bus_if.ram_en),   32'h0);
    check_val("oor_w_ram_we", 32'(bus_if.ram_we),   32'h0);
    check_val("oor_w_err0",   32'(bus_if.err_addr), 32'h0);
    next_cycle();
    bus_if.req = 3'b000;
    mid();
    check_val("oor_err",       32'(bus_if.err_addr), 32'h1);
    check_val("oor_w_rvalid",  32'(bus_if.rvalid),   32'h0);
    check_val("oor_mem2",      32'(mem[2]),          32'h042);
    next_cycle();
    bus_if.req  = 3'b001;
    bus_if.we   = 3'b000;
    bus_if.addr = 12'h00B;
    mid();
    check_val("oor_err_sticky", 32'(bus_if.err_addr), 32'h1);
    next_cycle();
    mid();
    check_val("oor_r_gnt",    32'(bus_if.gnt),    32'h1);
    check_val("oor_r_ram_en", 32'(bus_if.ram_en), 32'h0);
    next_cycle();
    bus_if.req = 3'b000;
    mid();
    check_val("oor_r_rvalid", 32'(bus_if.rvalid), 32'h1);
    check_val("oor_r_rdata",  32'(bus_if.rdata),  32'h0);

    // Reset in the fire cycle of a read.
    next_cycle();
    bus_if.req  = 3'b010;
    bus_if.addr = 12'h030;
    mid();
    check_val("mr_idle_gnt", 32'(bus_if.gnt), 32'h0);
    next_cycle();
    mid();
    check_val("mr_ram_en_pre", 32'(bus_if.ram_en), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_val("mr_gnt",    32'(bus_if.gnt),      32'h0);
    check_val("mr_ram_en", 32'(bus_if.ram_en),   32'h0);
    check_val("mr_rvalid", 32'(bus_if.rvalid),   32'h0);
    check_val("mr_err",    32'(bus_if.err_addr), 32'h0);
    next_cycle();
    mid();
    check_val("mr_no_rvalid", 32'(bus_if.rvalid), 32'h0);
    next_cycle();
    rst = 1'b0;
    bus_if.req  = 3'b011;
    bus_if.addr = 12'h033;
    mid();
    check_val("mr_rel_idle", 32'(bus_if.gnt), 32'h0);
    next_cycle();
    mid();
    check_val("mr_first_gnt", 32'(bus_if.gnt), 32'h1);
    next_cycle();
    bus_if.req = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
